// File: rtl/issue_scoreboard_if.sv
// Scoreboard types (minimal ariane_pkg subset) and the issue/writeback/commit
// interface of issue_scoreboard. Forwarding signals exist only with SB_OPERAND_FWD_EN.
package ariane_pkg;
  typedef enum logic [3:0] {NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR} fu_t;
  typedef enum logic [6:0] {ADD, SUB, ANDL, ORL, LD, SD, MUL, DIV, JALR, CSR_READ, CSR_WRITE} fu_op;
  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;
endpackage

interface issue_scoreboard_if #(
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned NR_WB_PORTS     = 4,
  parameter int unsigned NR_COMMIT_PORTS = 2
);
  import ariane_pkg::*;
  localparam int unsigned TID = $clog2(NR_ENTRIES);

  logic                                   flush_i;
  logic                                   issue_valid_i;
  logic                                   issue_ready_o;
  logic                                   full_o;
  logic [TID-1:0]                         issue_trans_id_o;
  logic [63:0]                            issue_pc_i;
  logic [63:0]                            issue_imm_i;
  fu_t                                    issue_fu_i;
  fu_op                                   issue_op_i;
  logic [4:0]                             issue_rs1_i;
  logic [4:0]                             issue_rs2_i;
  logic [4:0]                             issue_rd_i;
  exception                               issue_ex_i;
  logic [NR_WB_PORTS-1:0]                 wb_valid_i;
  logic [NR_WB_PORTS-1:0][TID-1:0]        wb_trans_id_i;
  logic [NR_WB_PORTS-1:0][63:0]           wb_data_i;
  exception [NR_WB_PORTS-1:0]             wb_ex_i;
  logic [NR_COMMIT_PORTS-1:0]             commit_valid_o;
  logic [NR_COMMIT_PORTS-1:0][63:0]       commit_pc_o;
  logic [NR_COMMIT_PORTS-1:0][63:0]       commit_result_o;
  fu_t [NR_COMMIT_PORTS-1:0]              commit_fu_o;
  fu_op [NR_COMMIT_PORTS-1:0]             commit_op_o;
  logic [NR_COMMIT_PORTS-1:0][4:0]        commit_rd_o;
  exception [NR_COMMIT_PORTS-1:0]         commit_ex_o;
  logic [NR_COMMIT_PORTS-1:0]             commit_ack_i;
  logic [31:0]                            rd_busy_o;
`ifdef SB_OPERAND_FWD_EN
  logic [1:0][4:0]                        fwd_rs_i;
  logic [1:0]                             fwd_valid_o;
  logic [1:0][63:0]                       fwd_data_o;
`endif

`ifdef SB_OPERAND_FWD_EN
  modport master (
    output flush_i, issue_valid_i, issue_pc_i, issue_imm_i, issue_fu_i, issue_op_i,
           issue_rs1_i, issue_rs2_i, issue_rd_i, issue_ex_i,
           wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i, commit_ack_i, fwd_rs_i,
    input  issue_ready_o, full_o, issue_trans_id_o, commit_valid_o, commit_pc_o,
           commit_result_o, commit_fu_o, commit_op_o, commit_rd_o, commit_ex_o,
           rd_busy_o, fwd_valid_o, fwd_data_o
  );
  modport slave (
    input  flush_i, issue_valid_i, issue_pc_i, issue_imm_i, issue_fu_i, issue_op_i,
           issue_rs1_i, issue_rs2_i, issue_rd_i, issue_ex_i,
           wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i, commit_ack_i, fwd_rs_i,
    output issue_ready_o, full_o, issue_trans_id_o, commit_valid_o, commit_pc_o,
           commit_result_o, commit_fu_o, commit_op_o, commit_rd_o, commit_ex_o,
           rd_busy_o, fwd_valid_o, fwd_data_o
  );
`else
  modport master (
    output flush_i, issue_valid_i, issue_pc_i, issue_imm_i, issue_fu_i, issue_op_i,
           issue_rs1_i, issue_rs2_i, issue_rd_i, issue_ex_i,
           wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i, commit_ack_i,
    input  issue_ready_o, full_o, issue_trans_id_o, commit_valid_o, commit_pc_o,
           commit_result_o, commit_fu_o, commit_op_o, commit_rd_o, commit_ex_o,
           rd_busy_o
  );
  modport slave (
    input  flush_i, issue_valid_i, issue_pc_i, issue_imm_i, issue_fu_i, issue_op_i,
           issue_rs1_i, issue_rs2_i, issue_rd_i, issue_ex_i,
           wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i, commit_ack_i,
    output issue_ready_o, full_o, issue_trans_id_o, commit_valid_o, commit_pc_o,
           commit_result_o, commit_fu_o, commit_op_o, commit_rd_o, commit_ex_o,
           rd_busy_o
  );
`endif
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue / out-of-order writeback / in-order commit scoreboard.
// Define SB_OPERAND_FWD_EN to build the two-port operand forwarding lookup.
module issue_scoreboard #(
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned NR_WB_PORTS     = 4,
  parameter int unsigned NR_COMMIT_PORTS = 2
) (
  input logic               clk_i,
  input logic               rst_i,
  issue_scoreboard_if.slave sb
);
  import ariane_pkg::*;

  localparam int unsigned TID = $clog2(NR_ENTRIES);
  localparam logic [TID:0] FULL_CNT = (TID+1)'(NR_ENTRIES);

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] result;
    fu_t         fu;
    fu_op        op;
    logic [4:0]  rd;
    exception    ex;
  } entry_t;

  entry_t                  mem_q [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]   occupied_q;
  logic [NR_ENTRIES-1:0]   finished_q;
  logic [TID-1:0]          issue_ptr_q;
  logic [TID-1:0]          commit_ptr_q;
  logic [TID:0]            count_q;

  logic                       full;
  logic                       issue_fire;
  logic [NR_COMMIT_PORTS-1:0] commit_valid;
  logic [NR_COMMIT_PORTS-1:0] retire_mask;
  logic [TID:0]               retire_cnt;
  logic [31:0]                rd_busy;

  assign full                = (count_q == FULL_CNT);
  assign issue_fire          = sb.issue_valid_i && !full;
  assign sb.full_o           = full;
  assign sb.issue_ready_o    = !full;
  assign sb.issue_trans_id_o = issue_ptr_q;
  assign sb.commit_valid_o   = commit_valid;
  assign sb.rd_busy_o        = rd_busy;

  // An excepting entry may only present at port 0 and blocks all younger ports.
  always_comb begin
    logic [TID-1:0] idx;
    logic           chain;
    chain        = 1'b1;
    commit_valid = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      idx                   = commit_ptr_q + TID'(k);
      commit_valid[k]       = chain && occupied_q[idx] && finished_q[idx] &&
                              ((k == 0) || !mem_q[idx].ex.valid);
      chain                 = commit_valid[k] && !mem_q[idx].ex.valid;
      sb.commit_pc_o[k]     = mem_q[idx].pc;
      sb.commit_result_o[k] = mem_q[idx].result;
      sb.commit_fu_o[k]     = mem_q[idx].fu;
      sb.commit_op_o[k]     = mem_q[idx].op;
      sb.commit_rd_o[k]     = mem_q[idx].rd;
      sb.commit_ex_o[k]     = mem_q[idx].ex;
    end
  end

  always_comb begin
    logic go;
    go          = 1'b1;
    retire_mask = '0;
    retire_cnt  = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      go             = go && sb.commit_ack_i[k] && commit_valid[k];
      retire_mask[k] = go;
      retire_cnt     = retire_cnt + {{TID{1'b0}}, go};
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (occupied_q[i] && !finished_q[i]) rd_busy[mem_q[i].rd] = 1'b1;
    end
    rd_busy[0] = 1'b0;
  end

`ifdef SB_OPERAND_FWD_EN
  // Walk oldest to youngest so the last match is the youngest writer.
  always_comb begin
    logic [TID-1:0] idx;
    logic [TID-1:0] sel;
    logic           hit;
    sb.fwd_valid_o = '0;
    sb.fwd_data_o  = '0;
    for (int i = 0; i < 2; i++) begin
      hit = 1'b0;
      sel = '0;
      for (int a = 0; a < NR_ENTRIES; a++) begin
        idx = commit_ptr_q + TID'(a);
        if (occupied_q[idx] && mem_q[idx].rd == sb.fwd_rs_i[i]) begin
          hit = 1'b1;
          sel = idx;
        end
      end
      sb.fwd_valid_o[i] = hit && (sb.fwd_rs_i[i] != 5'd0) && finished_q[sel] &&
                          !mem_q[sel].ex.valid;
      sb.fwd_data_o[i]  = sb.fwd_valid_o[i] ? mem_q[sel].result : 64'd0;
    end
  end
`endif

  // Writeback ports are applied in index order so the highest port wins a collision.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occupied_q   <= '0;
      finished_q   <= '0;
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) mem_q[i] <= '0;
    end else if (sb.flush_i) begin
      occupied_q   <= '0;
      finished_q   <= '0;
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) mem_q[i] <= '0;
    end else begin
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
        if (retire_mask[k]) begin
          occupied_q[commit_ptr_q + TID'(k)] <= 1'b0;
          finished_q[commit_ptr_q + TID'(k)] <= 1'b0;
        end
      end
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (sb.wb_valid_i[p] && occupied_q[sb.wb_trans_id_i[p]] &&
            !finished_q[sb.wb_trans_id_i[p]]) begin
          mem_q[sb.wb_trans_id_i[p]].result <= sb.wb_data_i[p];
          mem_q[sb.wb_trans_id_i[p]].ex     <= sb.wb_ex_i[p];
          finished_q[sb.wb_trans_id_i[p]]   <= 1'b1;
        end
      end
      if (issue_fire) begin
        mem_q[issue_ptr_q].pc     <= sb.issue_pc_i;
        mem_q[issue_ptr_q].result <= sb.issue_imm_i;
        mem_q[issue_ptr_q].fu     <= sb.issue_fu_i;
        mem_q[issue_ptr_q].op     <= sb.issue_op_i;
        mem_q[issue_ptr_q].rd     <= sb.issue_rd_i;
        mem_q[issue_ptr_q].ex     <= sb.issue_ex_i;
        occupied_q[issue_ptr_q]   <= 1'b1;
        finished_q[issue_ptr_q]   <= sb.issue_ex_i.valid;
        issue_ptr_q               <= issue_ptr_q + 1'b1;
      end
      commit_ptr_q <= commit_ptr_q + retire_cnt[TID-1:0];
      count_q      <= count_q + {{TID{1'b0}}, issue_fire} - retire_cnt;
    end
  end
endmodule
